// File: rtl/elevator_pkg.sv
// Shared types and helpers for the N-floor elevator controller.
package elevator_pkg;

    localparam int MAX_FLOORS = 32;

    typedef enum logic [1:0] {IDLE, MOVE, DOOR, SOS} state_t;
    typedef enum logic {UP, DOWN} dir_t;

    function automatic int floor_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic any_above(input logic [MAX_FLOORS-1:0] req, input int idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i > idx && req[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic any_below(input logic [MAX_FLOORS-1:0] req, input int idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i < idx && req[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/elevator_ctrl_tick_timer.sv
// Reloadable down-counter: load to MAX, decrement toward 0, otherwise hold.
// done_o marks the last counted cycle (count at 1 or below).
module tick_timer #(
    parameter int MAX = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);
    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(MAX);
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q <= CW'(1));

endmodule

// File: rtl/elevator_ctrl.sv
// N-floor elevator controller: latched calls, SCAN scheduling, travel/door timing, SOS, overweight.
// Define ELEVATOR_PARK_EN to return an idle cab to floor 0 after PARK_TICKS idle cycles.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int N_FLOORS     = 3,
    parameter int TRAVEL_TICKS = 2,
    parameter int DOOR_TICKS   = 3,
    parameter int PARK_TICKS   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] call_btn,
    input  logic                sos,
    input  logic                overweight,
    output logic [N_FLOORS-1:0] call_led,
    output logic [N_FLOORS-1:0] floor_pos,
    output logic                door_open,
    output logic                moving,
    output logic                sos_mode,
    output logic                weight_limit_exceeded
);
    localparam int FLOOR_W = floor_w(N_FLOORS);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);

    state_t              state_q, saved_q;
    dir_t                dir_q;
    logic [FLOOR_W-1:0]  floor_q, next_floor;
    logic [N_FLOORS-1:0] req_q, req_d, call_eff, clr_mask, here_oh, next_oh;
    logic                door_open_q, moving_q, sos_mode_q, wle_q;
    logic                req_here, req_next, call_here, arrive;
    logic                up_here, up_next, down_next, ahead_next, behind_next;
    logic                travel_load, travel_dec, travel_done;
    logic                door_hold, door_load, door_dec, door_done;
    logic                park_go, park_cont;

    genvar gi;
    generate
        for (gi = 0; gi < N_FLOORS; gi++) begin : g_floor
            assign here_oh[gi] = (floor_q == FLOOR_W'(gi));
            assign next_oh[gi] = (next_floor == FLOOR_W'(gi));
        end
    endgenerate

    // Neighbouring floor in the travel direction, saturating at both ends.
    always_comb begin
        next_floor = floor_q;
        if (dir_q == UP) begin
            if (floor_q != TOP_FLOOR) next_floor = floor_q + FLOOR_W'(1);
        end else if (floor_q != '0) begin
            next_floor = floor_q - FLOOR_W'(1);
        end
    end

    assign req_here    = |(req_q & here_oh);
    assign req_next    = |(req_q & next_oh);
    assign call_here   = |(call_btn & here_oh);
    assign arrive      = (state_q == MOVE) && travel_done;
    assign up_here     = any_above(MAX_FLOORS'(req_q), int'(floor_q));
    assign up_next     = any_above(MAX_FLOORS'(req_q), int'(next_floor));
    assign down_next   = any_below(MAX_FLOORS'(req_q), int'(next_floor));
    assign ahead_next  = (dir_q == UP) ? up_next : down_next;
    assign behind_next = (dir_q == UP) ? down_next : up_next;

    always_comb begin
        clr_mask = '0;
        if (state_q == IDLE && req_here) clr_mask = here_oh;
        else if (arrive && req_next)     clr_mask = next_oh;
    end

    always_comb begin
        call_eff = call_btn;
        if (state_q == SOS)       call_eff = '0;
        else if (state_q == DOOR) call_eff = call_btn & ~here_oh;
    end

    // Clear wins over a same-cycle call on the same floor.
    assign req_d = sos ? '0 : ((req_q | call_eff) & ~clr_mask);

    // Timers keep counting on the SOS entry edge and freeze while in SOS.
    assign travel_load = (state_q == IDLE) || arrive;
    assign travel_dec  = (state_q == MOVE) && !travel_done;
    assign door_hold   = overweight || call_here;
    assign door_load   = (state_q == IDLE) || (state_q == MOVE) || (state_q == DOOR && door_hold);
    assign door_dec    = (state_q == DOOR) && !door_hold;

    tick_timer #(.MAX(TRAVEL_TICKS)) u_travel_timer (
        .clk(clk), .rst_n(rst_n), .load_i(travel_load), .dec_i(travel_dec), .done_o(travel_done)
    );

    tick_timer #(.MAX(DOOR_TICKS)) u_door_timer (
        .clk(clk), .rst_n(rst_n), .load_i(door_load), .dec_i(door_dec), .done_o(door_done)
    );

`ifdef ELEVATOR_PARK_EN
    logic park_idle, park_load, park_done, parking_q;

    assign park_idle = (state_q == IDLE) && (req_q == '0) && (call_btn == '0) && (floor_q != '0);
    assign park_load = sos || !park_idle;
    assign park_go   = park_idle && park_done;
    assign park_cont = parking_q && (req_q == '0) && (next_floor != '0);

    tick_timer #(.MAX(PARK_TICKS)) u_park_timer (
        .clk(clk), .rst_n(rst_n), .load_i(park_load), .dec_i(!park_load), .done_o(park_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      parking_q <= 1'b0;
        else if (arrive)                 parking_q <= park_cont && !sos;
        else if (park_go && !sos)        parking_q <= 1'b1;
    end
`else
    assign park_go   = 1'b0;
    assign park_cont = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            saved_q     <= IDLE;
            dir_q       <= UP;
            floor_q     <= '0;
            req_q       <= '0;
            door_open_q <= 1'b0;
            moving_q    <= 1'b0;
            sos_mode_q  <= 1'b0;
            wle_q       <= 1'b0;
        end else begin
            req_q <= req_d;
            wle_q <= 1'b0;
            if (sos) begin
                sos_mode_q  <= 1'b1;
                moving_q    <= 1'b0;
                door_open_q <= 1'b0;
                if (state_q != SOS) begin
                    state_q <= SOS;
                    saved_q <= state_q;
                    // Arrival on the entry edge completes; the cab then rests there.
                    if (arrive) begin
                        floor_q <= next_floor;
                        saved_q <= IDLE;
                    end
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (req_here) begin
                            state_q     <= DOOR;
                            door_open_q <= 1'b1;
                        end else if (|req_q) begin
                            state_q  <= MOVE;
                            moving_q <= 1'b1;
                            dir_q    <= up_here ? UP : DOWN;
                        end else if (park_go) begin
                            state_q  <= MOVE;
                            moving_q <= 1'b1;
                            dir_q    <= DOWN;
                        end
                    end
                    MOVE: begin
                        if (travel_done) begin
                            floor_q <= next_floor;
                            if (req_next) begin
                                state_q     <= DOOR;
                                moving_q    <= 1'b0;
                                door_open_q <= 1'b1;
                            end else if (!(ahead_next || park_cont)) begin
                                if (behind_next) begin
                                    dir_q <= (dir_q == UP) ? DOWN : UP;
                                end else begin
                                    state_q  <= IDLE;
                                    moving_q <= 1'b0;
                                end
                            end
                        end
                    end
                    DOOR: begin
                        wle_q <= overweight;
                        if (!door_hold && door_done) begin
                            state_q     <= IDLE;
                            door_open_q <= 1'b0;
                        end
                    end
                    SOS: begin
                        state_q     <= saved_q;
                        sos_mode_q  <= 1'b0;
                        moving_q    <= (saved_q == MOVE);
                        door_open_q <= (saved_q == DOOR);
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign call_led              = req_q;
    assign floor_pos             = here_oh;
    assign door_open             = door_open_q;
    assign moving                = moving_q;
    assign sos_mode              = sos_mode_q;
    assign weight_limit_exceeded = wle_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed self-checking bench for elevator_ctrl (3 floors, travel 2, door 3, park 8).
module tb_elevator_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] call_btn;
    logic       sos;
    logic       overweight;
    logic [2:0] call_led;
    logic [2:0] floor_pos;
    logic       door_open;
    logic       moving;
    logic       sos_mode;
    logic       weight_limit_exceeded;

    int tests = 0;
    int fails = 0;

    logic [2:0] exp_b [4] = '{3'b001, 3'b001, 3'b010, 3'b010};
    logic       saw_door, saw_move;

    elevator_ctrl #(
        .N_FLOORS(3), .TRAVEL_TICKS(2), .DOOR_TICKS(3), .PARK_TICKS(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .call_btn(call_btn),
        .sos(sos),
        .overweight(overweight),
        .call_led(call_led),
        .floor_pos(floor_pos),
        .door_open(door_open),
        .moving(moving),
        .sos_mode(sos_mode),
        .weight_limit_exceeded(weight_limit_exceeded)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_led"},   8'(call_led), 8'h0);
        chk({tag, "_floor"}, 8'(floor_pos), 8'h1);
        chk({tag, "_door"},  8'(door_open), 8'h0);
        chk({tag, "_move"},  8'(moving), 8'h0);
        chk({tag, "_sos"},   8'(sos_mode), 8'h0);
        chk({tag, "_wle"},   8'(weight_limit_exceeded), 8'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; call_btn = '0; sos = 1'b0; overweight = 1'b0;
        tick(); tick();
        chk_reset("reset");
        rst_n = 1'b1;

        // Floor 0 -> 2: two floors of travel, then door dwell
        call_btn = 3'b100; tick(); call_btn = '0;
        chk("b_led", 8'(call_led), 8'h4);
        chk("b_idle", 8'(moving), 8'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_moving", 8'(moving), 8'h1);
            chk("b_floor", 8'(floor_pos), 8'(exp_b[i]));
        end
        tick();
        chk("b_arr_floor", 8'(floor_pos), 8'h4);
        chk("b_arr_move", 8'(moving), 8'h0);
        chk("b_arr_door", 8'(door_open), 8'h1);
        chk("b_arr_led", 8'(call_led), 8'h0);
        tick(); chk("b_door2", 8'(door_open), 8'h1);
        tick(); chk("b_door3", 8'(door_open), 8'h1);
        tick(); chk("b_door_close", 8'(door_open), 8'h0);

        // Floor 2 -> 1 (downward from rest)
        call_btn = 3'b010; tick(); call_btn = '0;
        tick(); chk("c_moving", 8'(moving), 8'h1);
        tick(); tick();
        chk("c_floor", 8'(floor_pos), 8'h2);
        chk("c_door", 8'(door_open), 8'h1);
        chk("c_led", 8'(call_led), 8'h0);
        tick(); tick(); tick();
        chk("c_close", 8'(door_open), 8'h0);

        // SCAN: going up 1 -> 2, floor 0 call mid-travel is served after floor 2
        call_btn = 3'b100; tick(); call_btn = '0;
        tick(); chk("d_moving", 8'(moving), 8'h1);
        tick();
        call_btn = 3'b001; tick(); call_btn = '0;
        chk("d_floor2", 8'(floor_pos), 8'h4);
        chk("d_door2", 8'(door_open), 8'h1);
        chk("d_led", 8'(call_led), 8'h1);
        tick(); tick(); tick();
        chk("d_close2", 8'(door_open), 8'h0);
        tick(); chk("d_rev_move", 8'(moving), 8'h1);
        tick(); tick();
        chk("d_pass1", 8'(floor_pos), 8'h2);
        chk("d_pass1_move", 8'(moving), 8'h1);
        tick(); tick();
        chk("d_floor0", 8'(floor_pos), 8'h1);
        chk("d_door0", 8'(door_open), 8'h1);
        chk("d_led0", 8'(call_led), 8'h0);

        // Overweight holds the door open, then 3-cycle dwell after release
        overweight = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("e_wle", 8'(weight_limit_exceeded), 8'h1);
            chk("e_door_held", 8'(door_open), 8'h1);
        end
        overweight = 1'b0;
        tick();
        chk("e_wle_clear", 8'(weight_limit_exceeded), 8'h0);
        chk("e_door_a", 8'(door_open), 8'h1);
        tick(); chk("e_door_b", 8'(door_open), 8'h1);
        tick(); chk("e_door_close", 8'(door_open), 8'h0);
        overweight = 1'b1; tick();
        chk("e_wle_closed", 8'(weight_limit_exceeded), 8'h0);
        overweight = 1'b0;

        // SOS mid-travel with one travel tick left
        call_btn = 3'b010; tick(); call_btn = '0;
        tick(); chk("f_moving", 8'(moving), 8'h1);
        sos = 1'b1; tick();
        chk("f_sos_move", 8'(moving), 8'h0);
        chk("f_sos_door", 8'(door_open), 8'h0);
        chk("f_sos_mode", 8'(sos_mode), 8'h1);
        chk("f_sos_led", 8'(call_led), 8'h0);
        chk("f_sos_floor", 8'(floor_pos), 8'h1);
        call_btn = 3'b100; tick(); call_btn = '0;
        chk("f_sos_ignore", 8'(call_led), 8'h0);
        sos = 1'b0; tick();
        chk("f_resume_move", 8'(moving), 8'h1);
        chk("f_resume_mode", 8'(sos_mode), 8'h0);
        chk("f_resume_floor", 8'(floor_pos), 8'h1);
        tick();
        chk("f_arrive_floor", 8'(floor_pos), 8'h2);
        chk("f_arrive_move", 8'(moving), 8'h0);

        // Go to floor 2, then observe the idle behaviour
        call_btn = 3'b100; tick(); call_btn = '0;
        tick(); tick(); tick();
        chk("h_floor2", 8'(floor_pos), 8'h4);
        chk("h_door", 8'(door_open), 8'h1);
        tick(); tick(); tick();
        chk("h_close", 8'(door_open), 8'h0);
        saw_door = 1'b0; saw_move = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            saw_door = saw_door | door_open;
            saw_move = saw_move | moving;
        end
        chk("h_no_door", 8'(saw_door), 8'h0);
`ifdef ELEVATOR_PARK_EN
        chk("h_park_move", 8'(saw_move), 8'h1);
        chk("h_park_floor", 8'(floor_pos), 8'h1);
`else
        chk("h_stay_move", 8'(saw_move), 8'h0);
        chk("h_stay_floor", 8'(floor_pos), 8'h4);
`endif

        // Asynchronous reset while the door is open at floor 2
        call_btn = 3'b100; tick(); call_btn = '0;
        for (int i = 0; i < 30; i++) begin
            if (door_open) break;
            tick();
        end
        chk("g_door_open", 8'(door_open), 8'h1);
        chk("g_floor2", 8'(floor_pos), 8'h4);
        #2 rst_n = 1'b0;
        #1 chk_reset("g_async");
        tick();
        rst_n = 1'b1;
        tick();
        chk("g_after_floor", 8'(floor_pos), 8'h1);
        chk("g_after_door", 8'(door_open), 8'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
